axi_slave_rr_arbiter: RTL and testbench
=======================================

// Module: axi_slave_rr_arbiter
// PURPOSE
//  Round-robin, transaction-locked arbiter sharing one AXI slave port between
//  NB_REQ requesters (core, debug, SPI-slave masters) on the ppu0 interconnect.
//  Grants one requester at a time and holds the grant from address issue until
//  the transaction completes (B handshake or last R beat).
//  A watchdog releases the slave port if completion never arrives.
// PARAMETERS
//  NB_REQ    3     number of requesters (>=2)
//  IDX_W     2     grant index width, $clog2(NB_REQ)
//  TIMEOUT   1024  cycles allowed in DATA before forced release; 0 disables
//  TO_W      11    watchdog counter width, must hold TIMEOUT
// PORTS
//  clk          in   1       core clock (clk_int domain)
//  rst          in   1       asynchronous reset, active-high
//  req_i        in   NB_REQ  per-requester address valid (AWVALID|ARVALID)
//  gnt_o        out  NB_REQ  one-hot grant, drives interconnect mux select
//  gnt_idx_o    out  IDX_W   binary index of current grant
//  addr_valid_o out  1       valid forwarded to slave = req_i[gnt_idx_o] in ADDR
//  addr_ready_i in   1       slave accepted address
//  done_i       in   1       transaction complete (BVALID&BREADY or RLAST&RVALID&RREADY)
//  busy_o       out  1       high in ADDR or DATA
//  timeout_o    out  1       one-cycle pulse on watchdog release
// BEHAVIOUR
//  Reset (async, rst=1): state IDLE; gnt_o=0, gnt_idx_o=0, addr_valid_o=0,
//   busy_o=0, timeout_o=0; priority pointer ptr=NB_REQ-1 (requester 0 first);
//   watchdog cleared. Reset mid-transaction aborts it silently, no timeout pulse.
//  FSM states: IDLE -> ADDR -> DATA -> IDLE.
//  IDLE: if |req_i, pick first set bit searching ptr+1, ptr+2, ... modulo NB_REQ;
//   register gnt_o/gnt_idx_o, go ADDR. Grant visible 1 cycle after req_i rises.
//   No request: stay IDLE, outputs 0.
//  ADDR: gnt_o stable; addr_valid_o = req_i[gnt_idx_o] (combinational).
//   addr_valid_o & addr_ready_i -> DATA, watchdog cleared.
//   req_i[gnt_idx_o] drops before acceptance -> IDLE, gnt_o=0, ptr unchanged.
//   done_i ignored in ADDR. Other requesters' req_i ignored (no preemption).
//  DATA: addr_valid_o=0, gnt_o held; watchdog increments each cycle.
//   done_i=1 -> IDLE next cycle, ptr<=gnt_idx_o, gnt_o=0.
//   watchdog reaches TIMEOUT-1 without done_i -> IDLE, timeout_o=1 for one
//   cycle, ptr<=gnt_idx_o. done_i and timeout in same cycle: done wins, no pulse.
//  Back-to-back: minimum 1 IDLE cycle between grants; re-arbitration always uses
//   updated ptr, so a continuously requesting master cannot starve others;
//   worst-case wait = (NB_REQ-1) transactions.
//  Pointer wrap: ptr+k computed modulo NB_REQ (no out-of-range index for
//   non-power-of-2 NB_REQ). gnt_o always one-hot or zero.
//  busy_o = (state!=IDLE). Throughput limited by the one-outstanding-txn design.
// TESTING
//  1 Reset then req_i=3'b001 -> gnt_o=001 next cycle; addr_ready_i=1 -> DATA;
//    done_i pulse -> gnt_o=000 next cycle, busy_o=0.
//  2 req_i=3'b111 held, done_i 3 cycles after each accept -> grants 0,1,2,0 in
//    order, one-hot, 1 IDLE cycle between each.
//  3 TIMEOUT=8, grant 1, accept, no done_i -> timeout_o=1 exactly 8 cycles after
//    accept, next grant goes to requester 2.
//  4 done_i and watchdog expiry coincide -> timeout_o stays 0, ptr updated.
//  5 Grant 2 in ADDR, req_i[2] drops before addr_ready_i -> IDLE, ptr unchanged,
//    next grant with req_i=3'b111 is requester 0.
//  6 rst asserted in DATA -> all outputs 0 asynchronously; after release,
//    req_i=3'b110 -> grant 1 (ptr reset to 2).

Source files
------------

// File: rtl/axi_slave_rr_arbiter.sv
// Round-robin, transaction-locked arbiter for one shared AXI slave port.
// Holds the grant from address issue to completion, with a watchdog release.
module axi_slave_rr_arbiter #(
  parameter int unsigned NB_REQ  = 3,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TO_W    = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NB_REQ-1:0] req_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]  gnt_idx_o,
  output logic              addr_valid_o,
  input  logic              addr_ready_i,
  input  logic              done_i,
  output logic              busy_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [TO_W-1:0]  wd;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             wd_expire;
  int unsigned      ptr_w;

  // Round-robin pick: first requester above ptr, otherwise wrap to the lowest.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    ptr_w    = 32'(ptr);
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (!pick_vld && req_i[i] && (i > ptr_w)) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NB_REQ; i++) begin
      if (!pick_vld && req_i[i]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end

  assign wd_expire    = (TIMEOUT != 0) && (wd == TO_W'(TIMEOUT - 1));
  assign addr_valid_o = (state == ADDR) && |(req_i & gnt_o);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_o     <= '0;
      gnt_idx_o <= '0;
      busy_o    <= 1'b0;
      timeout_o <= 1'b0;
      ptr       <= IDX_W'(NB_REQ - 1);
      wd        <= '0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= ADDR;
            gnt_o     <= NB_REQ'(1) << pick_idx;
            gnt_idx_o <= pick_idx;
            busy_o    <= 1'b1;
          end
        end
        ADDR: begin
          if (addr_valid_o && addr_ready_i) begin
            state <= DATA;
            wd    <= '0;
          end else if (!addr_valid_o) begin
            // Requester withdrew before acceptance: release without moving ptr.
            state     <= IDLE;
            gnt_o     <= '0;
            gnt_idx_o <= '0;
            busy_o    <= 1'b0;
          end
        end
        DATA: begin
          if (done_i || wd_expire) begin
            state     <= IDLE;
            ptr       <= gnt_idx_o;
            gnt_o     <= '0;
            gnt_idx_o <= '0;
            busy_o    <= 1'b0;
            timeout_o <= !done_i;
          end else begin
            wd <= wd + TO_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt_o     <= '0;
          gnt_idx_o <= '0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_rr_arbiter.sv
// Bench for axi_slave_rr_arbiter: directed and randomized transactions checked
// against a transaction-level round-robin model.
module tb_axi_slave_rr_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_i;
  logic [N-1:0] gnt_o;
  logic [1:0]   gnt_idx_o;
  logic         addr_valid_o;
  logic         addr_ready_i;
  logic         done_i;
  logic         busy_o;
  logic         timeout_o;

  int checks = 0;
  int errors = 0;
  int ptr_m;

  axi_slave_rr_arbiter #(
    .NB_REQ (N),
    .IDX_W  (2),
    .TIMEOUT(TO),
    .TO_W   (11)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .addr_valid_o(addr_valid_o),
    .addr_ready_i(addr_ready_i),
    .done_i      (done_i),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Winner = set requester with the smallest cyclic distance after ptr.
  function automatic int pick(input logic [N-1:0] req, input int p);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = 1000;
    for (int i = 0; i < int'(N); i++) begin
      if (req[i]) begin
        d = (i - p - 1 + 2 * int'(N)) % int'(N);
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt_o), 0);
    chk({tag, "_idx"}, 32'(gnt_idx_o), 0);
    chk({tag, "_avalid"}, 32'(addr_valid_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_timeout"}, 32'(timeout_o), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_i = '0;
    addr_ready_i = 1'b0;
    done_i = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    ptr_m = int'(N) - 1;
  endtask

  // One transaction starting from IDLE at a negedge. d = DATA cycle on which
  // done_i is sampled; d > TO means the watchdog releases instead.
  task automatic txn(input logic [N-1:0] req, input int acc, input int d, input bit drop);
    int g;
    int last;
    logic [N-1:0] gv;
    g  = pick(req, ptr_m);
    gv = N'(1) << g;
    req_i = req;
    done_i = 1'b0;
    addr_ready_i = 1'b0;
    @(negedge clk);
    chk("grant", 32'(gnt_o), 32'(gv));
    chk("grant_idx", 32'(gnt_idx_o), 32'(g));
    chk("busy_addr", 32'(busy_o), 1);
    chk("avalid_addr", 32'(addr_valid_o), 1);
    chk("timeout_low", 32'(timeout_o), 0);
    if (drop) begin
      req_i = req & ~gv;
      #1;
      chk("avalid_drop", 32'(addr_valid_o), 0);
      @(negedge clk);
      chk("drop_gnt", 32'(gnt_o), 0);
      chk("drop_busy", 32'(busy_o), 0);
      return;
    end
    for (int i = 0; i < acc; i++) begin
      done_i = 1'($urandom);
      req_i  = req | N'($urandom);
      @(negedge clk);
      chk("gnt_hold_addr", 32'(gnt_o), 32'(gv));
      chk("avalid_wait", 32'(addr_valid_o), 1);
    end
    addr_ready_i = 1'b1;
    done_i = 1'($urandom);
    @(negedge clk);
    addr_ready_i = 1'b0;
    chk("avalid_data", 32'(addr_valid_o), 0);
    chk("busy_data", 32'(busy_o), 1);
    chk("gnt_data", 32'(gnt_o), 32'(gv));
    last = (d < int'(TO)) ? d : int'(TO);
    for (int n = 1; n <= int'(TO); n++) begin
      done_i = (n == d);
      req_i  = N'($urandom);
      @(negedge clk);
      if (n == last) begin
        chk("end_gnt", 32'(gnt_o), 0);
        chk("end_busy", 32'(busy_o), 0);
        chk("end_timeout", 32'(timeout_o), (d > int'(TO)) ? 1 : 0);
        break;
      end
      chk("busy_hold", 32'(busy_o), 1);
      chk("no_early_timeout", 32'(timeout_o), 0);
      chk("gnt_hold_data", 32'(gnt_o), 32'(gv));
    end
    done_i = 1'b0;
    ptr_m = g;
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    req_i = '0;
    addr_ready_i = 1'b0;
    done_i = 1'b0;
    do_reset();

    // Single requester, then four fully contended rounds.
    txn(3'b001, 0, 3, 1'b0);
    for (int k = 0; k < 4; k++) txn(3'b111, 0, 3, 1'b0);

    // Watchdog release, then done coinciding with expiry.
    txn(3'b010, 1, TO + 5, 1'b0);
    txn(3'b111, 2, 2, 1'b0);
    txn(3'b111, 0, TO, 1'b0);
    txn(3'b111, 0, 1, 1'b0);

    // Withdrawn request right after reset leaves ptr at N-1.
    do_reset();
    txn(3'b100, 0, 1, 1'b1);
    txn(3'b111, 0, 2, 1'b0);

    // Reset in DATA aborts silently.
    @(negedge clk);
    req_i = 3'b001;
    @(negedge clk);
    addr_ready_i = 1'b1;
    @(negedge clk);
    addr_ready_i = 1'b0;
    chk("pre_reset_busy", 32'(busy_o), 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    req_i = '0;
    rst = 1'b0;
    ptr_m = int'(N) - 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_no_pulse", 32'(timeout_o), 0);
    end
    txn(3'b110, 0, 2, 1'b0);

    // Randomized transactions.
    for (int k = 0; k < 60; k++) begin
      txn(N'($urandom_range(1, 7)), int'($urandom_range(0, 3)),
          int'($urandom_range(1, TO + 3)), ($urandom_range(0, 4) == 0));
    end

    req_i = '0;
    @(negedge clk);
    chk("final_busy", 32'(busy_o), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
